// File: rtl/philv_pkg.sv
// rtl/philv_pkg.sv - shared opcodes, ALU codes, FSM states and control encodings
package philv_pkg;

    // Opcodes recognised by the decoder
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ALU function codes {instr[30], funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    // funct3 values that matter to the controller
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_SHR = 3'b101;

    // Register write-back source select
    localparam logic [1:0] WR_SRC_DMEM = 2'b00;
    localparam logic [1:0] WR_SRC_ALU  = 2'b01;
    localparam logic [1:0] WR_SRC_BYTE = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    // Instruction field positions
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       dmem_write;
        logic       reg_write;
        logic [1:0] reg_wr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
    } ctrl_t;

endpackage

// File: rtl/philv_alu.sv
// rtl/philv_alu.sv - combinational RV32I integer ALU
module philv_alu
    import philv_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic [3:0]           alu_funct,
    input  logic [BUS_WIDTH-1:0] alu_x,
    input  logic [BUS_WIDTH-1:0] alu_y,
    output logic [BUS_WIDTH-1:0] alu_z
);

    logic [4:0] shamt;
    assign shamt = alu_y[4:0];

    // Result selection; undefined codes yield zero
    always_comb begin
        alu_z = '0;
        case (alu_funct)
            ALU_ADD:  alu_z = alu_x + alu_y;
            ALU_SUB:  alu_z = alu_x - alu_y;
            ALU_SLL:  alu_z = alu_x << shamt;
            ALU_SLT:  alu_z[0] = $signed(alu_x) < $signed(alu_y);
            ALU_SLTU: alu_z[0] = alu_x < alu_y;
            ALU_XOR:  alu_z = alu_x ^ alu_y;
            ALU_SRL:  alu_z = alu_x >> shamt;
            ALU_SRA:  alu_z = $unsigned($signed(alu_x) >>> shamt);
            ALU_OR:   alu_z = alu_x | alu_y;
            ALU_AND:  alu_z = alu_x & alu_y;
            default:  alu_z = '0;
        endcase
    end

endmodule

// File: rtl/philv_decode_exec_ctrl.sv
// rtl/philv_decode_exec_ctrl.sv - multicycle controller FSM, decoder and ALU
module philv_decode_exec_ctrl
    import philv_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic [31:0]          instr,
    input  logic [BUS_WIDTH-1:0] alu_x,
    input  logic [BUS_WIDTH-1:0] alu_y,
    output logic [BUS_WIDTH-1:0] alu_z,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic [31:0]          immed,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 dmem_write,
    output logic                 reg_write,
    output logic [1:0]           reg_wr_src,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_i, is_load, is_store, supported;
    logic [3:0] alu_funct;

    state_t state_q, state_d;
    logic   run_q, run_d;
    ctrl_t  ctrl_q, ctrl_d;

    assign opcode = instr[6:0];
    assign funct3 = instr[FUNCT3_LSB +: 3];
    assign rs1    = instr[RS1_LSB +: 5];
    assign rs2    = instr[RS2_LSB +: 5];
    assign rd     = instr[RD_LSB +: 5];

    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign supported = is_r | is_i | is_load | is_store;

    // Immediate extraction by instruction format
    always_comb begin
        immed = '0;
        case (opcode)
            OP_I, OP_LOAD: immed = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:      immed = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:     immed = {{19{instr[31]}}, instr[31], instr[7],
                                    instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC: immed = {instr[31:12], 12'b0};
            OP_JAL:        immed = {{11{instr[31]}}, instr[31], instr[19:12],
                                    instr[20], instr[30:21], 1'b0};
            default:       immed = '0;
        endcase
    end

    // ALU function: decoded only in EXECUTE for R / I-ALU, ADD everywhere else
    always_comb begin
        alu_funct = ALU_ADD;
        if (state_q == ST_EXECUTE) begin
            if (is_r) begin
                alu_funct = {instr[30], funct3};
            end else if (is_i) begin
                alu_funct = (funct3 == F3_SHR) ? {instr[30], F3_SHR} : {1'b0, funct3};
            end
        end
    end

    // Next state plus the Moore outputs of that state, so outputs leave a flop
    always_comb begin
        run_d   = 1'b1;
        state_d = state_q;
        ctrl_d  = '0;
        if (!run_q) begin
            // First edge after reset release enters FETCH
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_FETCH:     state_d = ST_DECODE;
                ST_DECODE:    state_d = supported ? ST_EXECUTE : ST_FETCH;
                ST_EXECUTE:   state_d = ST_MEMORY;
                ST_MEMORY:    state_d = is_store ? ST_FETCH : ST_WRITEBACK;
                ST_WRITEBACK: state_d = ST_FETCH;
                default:      state_d = ST_FETCH;
            endcase
        end
        case (state_d)
            ST_FETCH: begin
                ctrl_d.ir_write  = 1'b1;
                ctrl_d.alu_src_b = SRC_B_FOUR;
            end
            ST_DECODE: ctrl_d.pc_write = 1'b1;
            ST_EXECUTE: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = is_r ? SRC_B_RS2 : SRC_B_IMM;
            end
            ST_MEMORY: ctrl_d.dmem_write = is_store;
            ST_WRITEBACK: begin
                ctrl_d.reg_write = 1'b1;
                if (is_load) begin
                    ctrl_d.reg_wr_src = (funct3 == F3_LB) ? WR_SRC_BYTE : WR_SRC_DMEM;
                end else begin
                    ctrl_d.reg_wr_src = WR_SRC_ALU;
                end
            end
            default: ctrl_d = '0;
        endcase
    end

    // State and registered control outputs; reset aborts any write in flight
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_FETCH;
            run_q   <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign pc_write   = ctrl_q.pc_write;
    assign ir_write   = ctrl_q.ir_write;
    assign dmem_write = ctrl_q.dmem_write;
    assign reg_write  = ctrl_q.reg_write;
    assign reg_wr_src = ctrl_q.reg_wr_src;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;

    philv_alu #(
        .BUS_WIDTH(BUS_WIDTH)
    ) u_alu (
        .alu_funct(alu_funct),
        .alu_x    (alu_x),
        .alu_y    (alu_y),
        .alu_z    (alu_z)
    );

endmodule

// File: tb/tb_philv_decode_exec_ctrl.sv
// tb/tb_philv_decode_exec_ctrl.sv - directed vector bench for philv_decode_exec_ctrl
module tb_philv_decode_exec_ctrl;

    logic        clk;
    logic        rstb;
    logic [31:0] instr;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [31:0] alu_z;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] immed;
    logic        pc_write, ir_write, dmem_write, reg_write;
    logic [1:0]  reg_wr_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    philv_decode_exec_ctrl #(.BUS_WIDTH(32)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .instr     (instr),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_z     (alu_z),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .immed     (immed),
        .pc_write  (pc_write),
        .ir_write  (ir_write),
        .dmem_write(dmem_write),
        .reg_write (reg_write),
        .reg_wr_src(reg_wr_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [14:0] regs;
        logic [31:0] imm;
        logic [2:0]  srcs;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstb = 1'b0;
        step();
        rstb = 1'b1;
    endtask

    function automatic logic [3:0] ens();
        return {ir_write, pc_write, dmem_write, reg_write};
    endfunction

    initial begin
        //            name     instr         x             y             z             {rs1,rs2,rd}          immed         {a,b}
        vecs[0]  = '{"add",   32'h002081B3, 32'd5,        32'd7,        32'd12,       {5'd1, 5'd2, 5'd3},  32'h0,        3'b100};
        vecs[1]  = '{"sub",   32'h402081B3, 32'd5,        32'd7,        32'hFFFFFFFE, {5'd1, 5'd2, 5'd3},  32'h0,        3'b100};
        vecs[2]  = '{"sra",   32'h4020D1B3, 32'h80000000, 32'd31,       32'hFFFFFFFF, {5'd1, 5'd2, 5'd3},  32'h0,        3'b100};
        vecs[3]  = '{"sltu",  32'h0020B1B3, 32'd1,        32'hFFFFFFFF, 32'd1,        {5'd1, 5'd2, 5'd3},  32'h0,        3'b100};
        vecs[4]  = '{"slt",   32'h0020A1B3, 32'd1,        32'hFFFFFFFF, 32'd0,        {5'd1, 5'd2, 5'd3},  32'h0,        3'b100};
        vecs[5]  = '{"addwr", 32'h002081B3, 32'hFFFFFFFF, 32'd1,        32'd0,        {5'd1, 5'd2, 5'd3},  32'h0,        3'b100};
        vecs[6]  = '{"sll",   32'h002091B3, 32'd1,        32'h24,       32'h10,       {5'd1, 5'd2, 5'd3},  32'h0,        3'b100};
        vecs[7]  = '{"xor",   32'h0020C1B3, 32'hF0F0,     32'h0FF0,     32'hFF00,     {5'd1, 5'd2, 5'd3},  32'h0,        3'b100};
        vecs[8]  = '{"srl",   32'h0020D1B3, 32'h80000000, 32'd31,       32'd1,        {5'd1, 5'd2, 5'd3},  32'h0,        3'b100};
        vecs[9]  = '{"or",    32'h0020E1B3, 32'hF0,       32'h0F,       32'hFF,       {5'd1, 5'd2, 5'd3},  32'h0,        3'b100};
        vecs[10] = '{"and",   32'h0020F1B3, 32'hF0,       32'h0F,       32'h0,        {5'd1, 5'd2, 5'd3},  32'h0,        3'b100};
        vecs[11] = '{"srai",  32'h4010D193, 32'h80000000, 32'd1,        32'hC0000000, {5'd1, 5'd1, 5'd3},  32'h401,      3'b110};
        vecs[12] = '{"addi30",32'hC0008193, 32'd5,        32'd3,        32'd8,        {5'd1, 5'd0, 5'd3},  32'hFFFFFC00, 3'b110};
        vecs[13] = '{"lw",    32'hFFC12183, 32'h100,      32'hFFFFFFFC, 32'hFC,       {5'd2, 5'd28, 5'd3}, 32'hFFFFFFFC, 3'b110};
        vecs[14] = '{"sw",    32'h0031A423, 32'h10,       32'd8,        32'h18,       {5'd3, 5'd3, 5'd8},  32'd8,        3'b110};

        rstb  = 1'b0;
        instr = 32'h00000013;
        alu_x = '0;
        alu_y = '0;
        step();
        chk("reset_ctrl", {24'b0, ens(), reg_wr_src, alu_src_a, alu_src_b}, 32'h0);

        // Fetch-to-execute for each vector, then check decode fields and the ALU result
        for (int i = 0; i < 15; i++) begin
            instr = vecs[i].instr;
            do_reset();
            step();
            alu_x = 32'h100;
            alu_y = 32'd4;
            #1;
            if (i == 1) chk("fetch_pc4", alu_z, 32'h104);
            step();
            step();
            alu_x = vecs[i].x;
            alu_y = vecs[i].y;
            #1;
            chk({vecs[i].name, "_z"},    alu_z, vecs[i].z);
            chk({vecs[i].name, "_regs"}, {17'b0, rs1, rs2, rd}, {17'b0, vecs[i].regs});
            chk({vecs[i].name, "_imm"},  immed, vecs[i].imm);
            chk({vecs[i].name, "_src"},  {29'b0, alu_src_a, alu_src_b}, {29'b0, vecs[i].srcs});
        end

        // ADDI: ir, pc, -, -, reg_write, then FETCH again
        instr = 32'h00000013;
        do_reset();
        begin
            logic [3:0] exp_seq [6] = '{4'b1000, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b1000};
            for (int c = 0; c < 6; c++) begin
                step();
                chk($sformatf("addi_en%0d", c), {28'b0, ens()}, {28'b0, exp_seq[c]});
                if (c == 0) chk("fetch_src", {29'b0, alu_src_a, alu_src_b}, 32'b001);
                if (c == 4) chk("addi_wbsrc", {30'b0, reg_wr_src}, 32'd1);
            end
        end

        // LB and LW write-back source
        instr = 32'hFFC10183;
        do_reset();
        for (int c = 0; c < 5; c++) step();
        chk("lb_wb", {27'b0, reg_write, 2'b0, reg_wr_src}, {27'b0, 1'b1, 4'b0010});
        instr = 32'hFFC12183;
        do_reset();
        for (int c = 0; c < 5; c++) step();
        chk("lw_wb", {27'b0, reg_write, 2'b0, reg_wr_src}, {27'b0, 1'b1, 4'b0000});

        // SW: 4 cycles, dmem_write in MEMORY, no reg_write
        instr = 32'h0031A423;
        do_reset();
        begin
            logic [3:0] exp_seq [6] = '{4'b1000, 4'b0100, 4'b0000, 4'b0010, 4'b1000, 4'b0100};
            for (int c = 0; c < 6; c++) begin
                step();
                chk($sformatf("sw_en%0d", c), {28'b0, ens()}, {28'b0, exp_seq[c]});
            end
        end

        // Unsupported opcode: FETCH, DECODE, FETCH
        instr = 32'hFFFFFFFF;
        do_reset();
        chk("nop_imm", immed, 32'h0);
        begin
            logic [3:0] exp_seq [3] = '{4'b1000, 4'b0100, 4'b1000};
            for (int c = 0; c < 3; c++) begin
                step();
                chk($sformatf("nop_en%0d", c), {28'b0, ens()}, {28'b0, exp_seq[c]});
            end
        end

        // Remaining immediate formats
        instr = 32'hFE000EE3; #1; chk("imm_b", immed, 32'hFFFFFFFC);
        instr = 32'h12345037; #1; chk("imm_u", immed, 32'h12345000);
        instr = 32'h0080006F; #1; chk("imm_j", immed, 32'h00000008);

        // Asynchronous reset in WRITEBACK
        instr = 32'h002081B3;
        do_reset();
        for (int c = 0; c < 5; c++) step();
        chk("wb_before_rst", {31'b0, reg_write}, 32'd1);
        #2;
        rstb = 1'b0;
        #1;
        chk("wb_async_rst", {24'b0, ens(), reg_wr_src, alu_src_a, alu_src_b}, 32'h0);
        step();
        rstb = 1'b1;
        step();
        chk("rst_to_fetch", {28'b0, ens()}, 32'b1000);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
